// File: rtl/mem_port_sched.sv
// Two-requester round-robin scheduler for a single-port word-line memory array.
// Each transaction runs grant -> decode -> one-cycle word-line access -> response.
module mem_port_sched #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               req,
    input  logic [1:0]               we,
    input  logic [2*ADDR_W-1:0]      addr,
    input  logic [2*DATA_W-1:0]      wdata,
    output logic [1:0]               gnt,
    output logic [1:0]               ack,
    output logic [DATA_W-1:0]        rdata,
    output logic                     busy,
    output logic [(1<<ADDR_W)-1:0]   mem_wl,
    output logic                     mem_we,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_last;
    logic                  r_we_l;
    logic [ADDR_W-1:0]     r_addr_l;
    logic [DATA_W-1:0]     r_wdata_l;
    logic [1:0]            r_gnt;
    logic [1:0]            r_ack;
    logic [DATA_W-1:0]     r_rdata;
    logic                  r_busy;
    logic [DEPTH-1:0]      r_wl;
    logic                  r_mem_we;
    logic [DATA_W-1:0]     r_mem_wdata;

    logic                  w_winner;
    logic                  w_we_sel;
    logic [ADDR_W-1:0]     w_addr_sel;
    logic [DATA_W-1:0]     w_wdata_sel;

    function automatic logic [1:0] onehot2(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [DEPTH-1:0] decode_wl(input logic [ADDR_W-1:0] a);
        logic [DEPTH-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    // With both requesting, the one that did not win last time goes next.
    always_comb begin
        w_winner    = (req == 2'b11) ? ~r_last : req[1];
        w_we_sel    = w_winner ? we[1] : we[0];
        w_addr_sel  = w_winner ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
        w_wdata_sel = w_winner ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_last      <= 1'b1;
            r_we_l      <= 1'b0;
            r_addr_l    <= '0;
            r_wdata_l   <= '0;
            r_gnt       <= 2'b00;
            r_ack       <= 2'b00;
            r_rdata     <= '0;
            r_busy      <= 1'b0;
            r_wl        <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_last    <= w_winner;
                        r_we_l    <= w_we_sel;
                        r_addr_l  <= w_addr_sel;
                        r_wdata_l <= w_wdata_sel;
                        r_gnt     <= onehot2(w_winner);
                        r_busy    <= 1'b1;
                        r_state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_gnt       <= 2'b00;
                    r_wl        <= decode_wl(r_addr_l);
                    r_mem_we    <= r_we_l;
                    r_mem_wdata <= r_wdata_l;
                    r_state     <= S_ACCESS;
                end
                // Word line is live for exactly this cycle; read data is captured as it closes.
                S_ACCESS: begin
                    r_rdata     <= r_we_l ? '0 : mem_rdata;
                    r_wl        <= '0;
                    r_mem_we    <= 1'b0;
                    r_mem_wdata <= '0;
                    r_ack       <= onehot2(r_last);
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    r_ack   <= 2'b00;
                    r_rdata <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign ack       = r_ack;
    assign rdata     = r_rdata;
    assign busy      = r_busy;
    assign mem_wl    = r_wl;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;

endmodule
